// File: rtl/rx_pkg.sv
// rx_pkg: shared width limits and length helpers for the RX deserializer.
package rx_pkg;
    localparam int RX_MAX_WIDTH = 16;

    function automatic int rx_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Out-of-range frame lengths fall back to the full data width.
    function automatic int clamp_len(input int len, input int max_w);
        return (len == 0 || len > max_w) ? max_w : len;
    endfunction
endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: per-frame bit counter with latched frame length and last-bit flag.
module rx_bit_counter
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = rx_cnt_w(DATA_WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_len,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] len,
    output logic             last_bit
);
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_cfg;

    assign len_cfg  = CNT_W'(clamp_len(int'(cfg_len), DATA_WIDTH));
    // The first bit of a frame already obeys the length it latches.
    assign len      = (bit_cnt == '0) ? len_cfg : len_q;
    assign last_bit = (bit_cnt == len - CNT_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
            len_q   <= CNT_W'(DATA_WIDTH);
        end else begin
            if (start)
                bit_cnt <= '0;
            else if (en)
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            if (start || (en && bit_cnt == '0))
                len_q <= len_cfg;
        end
    end
endmodule

// File: rtl/rx_deser_param.sv
// rx_deser_param: runtime-length serial-to-parallel deserializer with
// valid/ready output register, word parity and sticky overrun.
module rx_deser_param
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1,
    parameter int CNT_W      = rx_cnt_w(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  deser_start,
    input  logic                  deser_en,
    input  logic                  sampled_bit,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic                  out_ready,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  out_valid,
    output logic                  par_calc,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  busy,
    output logic                  overrun
);
    if (DATA_WIDTH < 2 || DATA_WIDTH > RX_MAX_WIDTH) begin : g_bad_width
        $error("rx_deser_param: DATA_WIDTH out of range");
    end

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      idx;
    logic                  last_bit;
    logic                  cap;
    logic                  done;

    rx_bit_counter #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .start    (deser_start),
        .en       (deser_en),
        .cfg_len  (cfg_len),
        .bit_cnt  (bit_cnt),
        .len      (len),
        .last_bit (last_bit)
    );

    // Start beats capture, so a bit arriving with deser_start is dropped.
    assign cap  = deser_en && !deser_start;
    assign done = cap && last_bit;
    assign busy = (bit_cnt != '0);
    assign idx  = LSB_FIRST ? bit_cnt : len - CNT_W'(1) - bit_cnt;
    assign word = cap ? shreg | ({{(DATA_WIDTH-1){1'b0}}, sampled_bit} << idx) : shreg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg     <= '0;
            P_DATA    <= '0;
            par_calc  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            shreg <= (deser_start || done) ? '0 : word;
            if (done) begin
                P_DATA   <= word;
                par_calc <= ^word;
            end
            if (done)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (done && out_valid && !out_ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_deser_param.sv
// tb_rx_deser_param: directed table and sequence checks for rx_deser_param (LSB- and MSB-first).
module tb_rx_deser_param;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          deser_start = 1'b0, deser_en = 1'b0, sampled_bit = 1'b0;
    logic          out_ready = 1'b0, ovr_clr = 1'b0;
    logic [CW-1:0] cfg_len = 4'd8;

    logic [DW-1:0] pd, pd_m;
    logic          vld, vld_m, par, par_m, bsy, bsy_m, ovr, ovr_m;
    logic [CW-1:0] cnt, cnt_m;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 CLK = ~CLK;

    rx_deser_param #(.DATA_WIDTH(DW), .LSB_FIRST(1)) dut (
        .CLK(CLK), .RST(RST), .deser_start(deser_start), .deser_en(deser_en),
        .sampled_bit(sampled_bit), .cfg_len(cfg_len), .out_ready(out_ready),
        .ovr_clr(ovr_clr), .P_DATA(pd), .out_valid(vld), .par_calc(par),
        .bit_cnt(cnt), .busy(bsy), .overrun(ovr)
    );

    rx_deser_param #(.DATA_WIDTH(DW), .LSB_FIRST(0)) dut_m (
        .CLK(CLK), .RST(RST), .deser_start(deser_start), .deser_en(deser_en),
        .sampled_bit(sampled_bit), .cfg_len(cfg_len), .out_ready(out_ready),
        .ovr_clr(ovr_clr), .P_DATA(pd_m), .out_valid(vld_m), .par_calc(par_m),
        .bit_cnt(cnt_m), .busy(bsy_m), .overrun(ovr_m)
    );

    typedef struct {
        logic          st, en, b, rdy;
        logic [CW-1:0] len;
        logic [DW-1:0] e_pd;
        logic          e_vld, e_par, e_ovr;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic b);
        deser_en = 1'b1;
        sampled_bit = b;
        cyc();
        deser_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[i]);
    endtask

    function automatic vec_t mk(input logic st, en, b, rdy, input logic [DW-1:0] e_pd,
                                input logic e_vld, e_par, input logic [CW-1:0] e_cnt);
        vec_t v;
        v.st = st; v.en = en; v.b = b; v.rdy = rdy; v.len = 4'd8;
        v.e_pd = e_pd; v.e_vld = e_vld; v.e_par = e_par; v.e_ovr = 1'b0; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        logic [7:0] t1 = 8'hA5;
        logic [7:0] t5 = 8'h3C;
        for (int i = 0; i < 7; i++) tbl[i] = mk(0, 1, t1[i], 0, 8'h00, 0, 0, 4'(i + 1));
        tbl[7]  = mk(0, 1, t1[7], 0, 8'hA5, 1, 0, 4'd0);
        tbl[8]  = mk(0, 0, 0,     1, 8'hA5, 0, 0, 4'd0);
        tbl[9]  = mk(1, 0, 0,     0, 8'hA5, 0, 0, 4'd0);
        tbl[10] = mk(0, 1, 1,     0, 8'hA5, 0, 0, 4'd1);
        tbl[11] = mk(0, 1, 1,     0, 8'hA5, 0, 0, 4'd2);
        tbl[12] = mk(0, 1, 1,     0, 8'hA5, 0, 0, 4'd3);
        tbl[13] = mk(1, 0, 0,     0, 8'hA5, 0, 0, 4'd0);
        tbl[14] = mk(1, 1, 1,     0, 8'hA5, 0, 0, 4'd0);
        for (int i = 0; i < 7; i++) tbl[15 + i] = mk(0, 1, t5[i], 0, 8'hA5, 0, 0, 4'(i + 1));
        tbl[22] = mk(0, 1, t5[7], 0, 8'h3C, 1, 0, 4'd0);
        tbl[23] = mk(0, 0, 0,     1, 8'h3C, 0, 0, 4'd0);

        #12;
        chk("rst_pdata", 32'(pd), 0);
        chk("rst_valid", 32'(vld), 0);
        chk("rst_par",   32'(par), 0);
        chk("rst_cnt",   32'(cnt), 0);
        chk("rst_busy",  32'(bsy), 0);
        chk("rst_ovr",   32'(ovr), 0);
        @(negedge CLK);
        RST = 1'b0;

        // T1 and T5 as a per-cycle table
        for (int i = 0; i < 24; i++) begin
            deser_start = tbl[i].st; deser_en = tbl[i].en; sampled_bit = tbl[i].b;
            out_ready = tbl[i].rdy; cfg_len = tbl[i].len;
            cyc();
            chk($sformatf("tbl%0d_pdata", i), 32'(pd),  32'(tbl[i].e_pd));
            chk($sformatf("tbl%0d_valid", i), 32'(vld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_par", i),   32'(par), 32'(tbl[i].e_par));
            chk($sformatf("tbl%0d_cnt", i),   32'(cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ovr", i),   32'(ovr), 32'(tbl[i].e_ovr));
        end
        deser_start = 1'b0; deser_en = 1'b0; out_ready = 1'b0;

        // T2: 5-bit frame, MSB first 1,0,1,1,0
        cfg_len = 4'd5;
        deser_start = 1'b1; cyc(); deser_start = 1'b0;
        send(1); send(0); send(1); send(1);
        chk("t2_cnt4", 32'(cnt_m), 4);
        send(0);
        chk("t2_msb_pdata", 32'(pd_m), 32'h16);
        chk("t2_msb_par",   32'(par_m), 1);
        chk("t2_msb_valid", 32'(vld_m), 1);
        chk("t2_msb_ovr",   32'(ovr_m), 0);
        chk("t2_lsb_pdata", 32'(pd), 32'h0D);
        chk("t2_cnt0",      32'(cnt_m), 0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        chk("t2_accept", 32'(vld_m), 0);

        // T3: two unconsumed words -> overrun
        cfg_len = 4'd8;
        send_word(8'h11, 8);
        chk("t3_w1_pdata", 32'(pd), 32'h11);
        chk("t3_w1_ovr",   32'(ovr), 0);
        send_word(8'h22, 8);
        chk("t3_w2_pdata", 32'(pd), 32'h22);
        chk("t3_w2_valid", 32'(vld), 1);
        chk("t3_w2_ovr",   32'(ovr), 1);
        ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
        chk("t3_clr_ovr",   32'(ovr), 0);
        chk("t3_clr_valid", 32'(vld), 1);

        // T4: accept on the completion edge
        send_word(8'h81, 7);
        out_ready = 1'b1;
        send(1);
        chk("t4_pdata", 32'(pd), 32'h81);
        chk("t4_valid", 32'(vld), 1);
        chk("t4_ovr",   32'(ovr), 0);
        chk("t4_par",   32'(par), 0);
        cyc(); out_ready = 1'b0;
        chk("t4_drain", 32'(vld), 0);

        // length 1, then overrun set against ovr_clr on the same edge
        cfg_len = 4'd1;
        send(1);
        chk("l1_pdata", 32'(pd), 1);
        chk("l1_valid", 32'(vld), 1);
        chk("l1_par",   32'(par), 1);
        chk("l1_cnt",   32'(cnt), 0);
        chk("l1_msb",   32'(pd_m), 1);
        ovr_clr = 1'b1;
        send(0);
        ovr_clr = 1'b0;
        chk("l1_setwins", 32'(ovr), 1);
        chk("l1_pdata2",  32'(pd), 0);

        // T6: async reset mid-frame, then cfg_len=0 gives an 8-bit frame
        cfg_len = 4'd0;
        send_word(8'h0F, 4);
        chk("t6_cnt4",  32'(cnt), 4);
        chk("t6_busy",  32'(bsy), 1);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_pdata", 32'(pd), 0);
        chk("t6_rst_valid", 32'(vld), 0);
        chk("t6_rst_cnt",   32'(cnt), 0);
        chk("t6_rst_busy",  32'(bsy), 0);
        chk("t6_rst_ovr",   32'(ovr), 0);
        chk("t6_rst_par",   32'(par), 0);
        @(negedge CLK);
        RST = 1'b0;
        send_word(8'h5A, 7);
        chk("t6_len0_cnt7",  32'(cnt), 7);
        chk("t6_len0_valid", 32'(vld), 0);
        send(0);
        chk("t6_len0_pdata", 32'(pd), 32'h5A);
        chk("t6_len0_done",  32'(vld), 1);
        chk("t6_len0_cnt0",  32'(cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
